// File: rtl/fifo_mem_drain_if.sv
// fifo_mem_drain_if
// Bundles the control, FIFO-read and memory-write signals of the
// fifo_mem_drain stage.
//   master : the environment (start/base_addr request, FIFO flags and data)
//   slave  : the drain stage (pop strobe, memory write port, status)
// Signals:
//   start, base_addr            : transfer request and first write address
//   fifo_empty, fifo_rd_data    : FIFO status and registered read data
//   fifo_pop                    : FIFO pop strobe
//   mem_we, mem_waddr, mem_wdata: memory write port
//   busy, done, words_written   : transfer status
interface fifo_mem_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 5
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_pop;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  words_written;

  modport master (
    output start, base_addr, fifo_empty, fifo_rd_data,
    input  fifo_pop, mem_we, mem_waddr, mem_wdata, busy, done, words_written
  );

  modport slave (
    input  start, base_addr, fifo_empty, fifo_rd_data,
    output fifo_pop, mem_we, mem_waddr, mem_wdata, busy, done, words_written
  );
endinterface

// File: rtl/fifo_mem_drain.sv
// fifo_mem_drain
// Drain stage behind the result FIFO: after a start request it pops exactly
// DATA_AMOUNT words and writes them to consecutive (wrapping) addresses of a
// memory write port, then pulses done.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : fifo_mem_drain_if slave modport (request, FIFO read side,
//           memory write side, status)
module fifo_mem_drain #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int DATA_AMOUNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  fifo_mem_drain_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int CNT_WIDTH  = $clog2(DATA_AMOUNT + 1);

  localparam logic [CNT_WIDTH-1:0]  AMOUNT    = CNT_WIDTH'(DATA_AMOUNT);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(DATA_AMOUNT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  popped_q, popped_d;
  logic [CNT_WIDTH-1:0]  written_q, written_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  // Pop issued last cycle: the FIFO read data is valid now, so write it.
  logic                  wr_pend_q, wr_pend_d;
  logic                  pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      popped_q  <= '0;
      written_q <= '0;
      wptr_q    <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      popped_q  <= popped_d;
      written_q <= written_d;
      wptr_q    <= wptr_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    popped_d  = popped_q;
    written_d = written_q;
    wptr_d    = wptr_q;
    pop       = 1'b0;

    // Write pipeline runs independently of the state: every pending word is
    // committed and advances the pointer (modulo MEM_DEPTH) and the count.
    if (wr_pend_q) begin
      written_d = written_q + CNT_ONE;
      wptr_d    = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = DRAIN;
          wptr_d    = bus.base_addr;
          popped_d  = '0;
          written_d = '0;
        end
      end
      DRAIN: begin
        pop = !bus.fifo_empty && (popped_q < AMOUNT);
        if (pop) begin
          popped_d = popped_q + CNT_ONE;
          if (popped_q == LAST_CNT) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (wr_pend_q && (written_q == LAST_CNT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_pend_d = pop;
  end

  assign bus.fifo_pop      = pop;
  assign bus.mem_we        = wr_pend_q;
  assign bus.mem_waddr     = wptr_q;
  // FIFO data is only valid in the cycle after a pop; pass it through then
  // and hold zero otherwise so the port is quiet outside writes.
  assign bus.mem_wdata     = wr_pend_q ? bus.fifo_rd_data : '0;
  assign bus.busy          = (state_q == DRAIN) || (state_q == FLUSH);
  assign bus.done          = (state_q == DONE);
  assign bus.words_written = written_q;

endmodule

// File: tb/tb_fifo_mem_drain.sv
module tb_fifo_mem_drain;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AMT   = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_mem_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  fifo_mem_drain #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .DATA_AMOUNT(AMT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Environment: FIFO contents (popped on the DUT's strobe), the ordered
  // stream of every word pushed, and a memory image built from mem_we.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] stream[$];
  logic [DW-1:0] mem_m[DEPTH];
  int            rd_idx;
  int            dut_pops;
  int            push_left;
  int            push_period;
  int            cyc;

  // Reference model of the transfer, in terms of pops/writes counts.
  bit m_act, m_wr_pend, m_done;
  int m_pops, m_writes, m_base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    stream.push_back(d);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic flush_env();
    fifo_q.delete();
    stream.delete();
    rd_idx         = 0;
    push_left      = 0;
    bus.fifo_empty = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model and
  // the FIFO just after the rising edge.
  task automatic cycle();
    bit            pop_exp, dut_pop, start_acc;
    logic [DW-1:0] ew;
    @(negedge clk);
    pop_exp = m_act && (fifo_q.size() > 0) && (m_pops < AMT);
    check("fifo_pop", bus.fifo_pop, pop_exp);
    check("mem_we", bus.mem_we, m_wr_pend);
    if (m_wr_pend) begin
      ew = (rd_idx < stream.size()) ? stream[rd_idx] : '0;
      check("mem_waddr", bus.mem_waddr, (m_base + m_writes) % DEPTH);
      check("mem_wdata", bus.mem_wdata, ew);
    end
    check("busy", bus.busy, m_act);
    check("done", bus.done, m_done);
    check("words_written", bus.words_written, m_writes);
    if (bus.mem_we) mem_m[bus.mem_waddr] = bus.mem_wdata;
    dut_pop   = bus.fifo_pop;
    if (dut_pop) dut_pops++;
    start_acc = bus.start && !m_act && !m_done;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (m_wr_pend) begin
      m_writes++;
      rd_idx++;
      if (m_writes == AMT) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
    end
    m_wr_pend = pop_exp;
    if (pop_exp) m_pops++;
    if (dut_pop && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
    if (start_acc) begin
      m_act    = 1'b1;
      m_base   = int'(bus.base_addr);
      m_pops   = 0;
      m_writes = 0;
    end
    cyc++;
    if (push_left > 0 && (cyc % push_period) == 0) begin
      push_word($urandom);
      push_left--;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  // Full transfer from base; optional stray start (with another base) at
  // iteration restart_at. Checks done, pop count and the memory image.
  task automatic run_xfer(input int base, input int restart_at);
    int first;
    bit finished;
    first          = rd_idx;
    dut_pops       = 0;
    finished       = 1'b0;
    bus.start      = 1'b1;
    bus.base_addr  = AW'(base);
    cycle();
    bus.start      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == restart_at) begin
        bus.start     = 1'b1;
        bus.base_addr = AW'(base + 5);
      end
      cycle();
      bus.start = 1'b0;
      if (m_done) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check("timeout", 0, 1);
    cycle();
    check("pop_count", dut_pops, AMT);
    for (int k = 0; k < AMT; k++) begin
      logic [DW-1:0] w;
      w = (first + k < stream.size()) ? stream[first + k] : '0;
      check("mem_image", mem_m[(base + k) % DEPTH], w);
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.base_addr    = '0;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    m_act = 0; m_wr_pend = 0; m_done = 0; m_pops = 0; m_writes = 0; m_base = 0;
    cyc = 0; push_period = 1; dut_pops = 0;
    flush_env();
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_waddr", bus.mem_waddr, 0);
    check("rst_words", bus.words_written, 0);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // 1: sequential data from address 0
    flush_env();
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    run_xfer(0, -1);
    check("t1_ww", bus.words_written, 16);

    // 2: wrapping addresses from 12
    flush_env();
    for (int i = 0; i < 16; i++) push_word(DW'(100 + i));
    run_xfer(12, -1);

    // 3: FIFO starves; refilled one word every third cycle
    flush_env();
    for (int i = 0; i < 4; i++) push_word($urandom);
    push_left   = 12;
    push_period = 3;
    run_xfer(5, -1);

    // 4: surplus words stay in the FIFO
    flush_env();
    for (int i = 0; i < 20; i++) push_word($urandom);
    run_xfer(2, -1);
    check("t4_left", fifo_q.size(), 4);
    check("t4_empty", bus.fifo_empty, 0);
    cycle();
    check("t4_no_extra_pop", dut_pops, AMT);

    // 5: stray start mid-transfer ignored; back-to-back transfer afterwards
    flush_env();
    for (int i = 0; i < 32; i++) push_word($urandom);
    run_xfer(3, 5);
    run_xfer(9, -1);

    // random transfers with random starvation patterns
    for (int r = 0; r < 6; r++) begin
      int pre;
      flush_env();
      pre = int'($urandom_range(0, 10));
      for (int i = 0; i < pre; i++) push_word($urandom);
      push_left   = 16 - pre + int'($urandom_range(0, 4));
      push_period = int'($urandom_range(1, 4));
      if (pre == 0) push_word($urandom);
      run_xfer(int'($urandom_range(0, DEPTH - 1)), -1);
    end

    // 6: asynchronous reset after the 7th write
    flush_env();
    for (int i = 0; i < 16; i++) push_word($urandom);
    bus.start     = 1'b1;
    bus.base_addr = AW'(6);
    cycle();
    bus.start = 1'b0;
    for (int i = 0; i < 100 && m_writes < 7; i++) cycle();
    check("t6_seven", m_writes, 7);
    #2;
    reset = 1'b0;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_pop", bus.fifo_pop, 0);
    check("t6_we", bus.mem_we, 0);
    check("t6_waddr", bus.mem_waddr, 0);
    check("t6_wdata", bus.mem_wdata, 0);
    check("t6_words", bus.words_written, 0);
    m_act = 0; m_wr_pend = 0; m_done = 0; m_pops = 0; m_writes = 0;
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    flush_env();
    for (int i = 0; i < 16; i++) push_word($urandom);
    run_xfer(1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
